// File: rtl/max_pool_pkg.sv
// Shared types for the 2x2/stride-2 max-pool sequencer: FSM state encoding and the
// fp32 sign helper used to interpret the external comparator's A-B result.
package max_pool_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FILL,
    S_R0,
    S_R1,
    S_R2,
    S_R3,
    S_C3,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [31:0] SIGN_MASK = 32'h8000_0000;

  // A negative A-B means A < B.
  function automatic logic is_neg(input logic [31:0] s);
    return (s & SIGN_MASK) != '0;
  endfunction

endpackage

// File: rtl/max_pool_addr_gen.sv
// Window walker for the 2x2/stride-2 pool: (c,r,k) counters, c outermost and k innermost,
// plus the four tap addresses of the current window in raster channel>row>col order.
module max_pool_addr_gen
  import max_pool_pkg::*;
#(
  parameter int unsigned CHANNEL = 2,
  parameter int unsigned ROW     = 4,
  parameter int unsigned COL     = 4,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              clear,
  input  logic              step,
  output logic [ADDR_W-1:0] p0,
  output logic [ADDR_W-1:0] p1,
  output logic [ADDR_W-1:0] p2,
  output logic [ADDR_W-1:0] p3,
  output logic              last
);

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(CHANNEL - 1);
  localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(ROW - 2);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(COL - 2);
  localparam logic [ADDR_W-1:0] ROW_W  = ADDR_W'(ROW);
  localparam logic [ADDR_W-1:0] COL_W  = ADDR_W'(COL);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO    = ADDR_W'(2);

  logic [ADDR_W-1:0] c_q, r_q, k_q;
  logic              c_end, r_end, k_end;

  assign c_end = (c_q == C_LAST);
  assign r_end = (r_q == R_LAST);
  assign k_end = (k_q == K_LAST);

  // Wrap by equality with the last position so the +2 step never has to overflow.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      c_q <= '0;
      r_q <= '0;
      k_q <= '0;
    end else if (clear) begin
      c_q <= '0;
      r_q <= '0;
      k_q <= '0;
    end else if (step) begin
      if (!k_end) begin
        k_q <= k_q + TWO;
      end else begin
        k_q <= '0;
        if (!r_end) begin
          r_q <= r_q + TWO;
        end else begin
          r_q <= '0;
          c_q <= c_end ? '0 : c_q + ONE;
        end
      end
    end
  end

  assign p0   = (c_q * ROW_W + r_q) * COL_W + k_q;
  assign p1   = p0 + ONE;
  assign p2   = p0 + COL_W;
  assign p3   = p2 + ONE;
  assign last = c_end & r_end & k_end;

endmodule

// File: rtl/max_pool_ctrl.sv
// 2x2/stride-2 max-pool sequencer: fills the feature-map buffer, then walks each window
// with three time-multiplexed compares on one shared external fp32 comparator.
module max_pool_ctrl
  import max_pool_pkg::*;
#(
  parameter int unsigned BIT     = 32,
  parameter int unsigned CHANNEL = 2,
  parameter int unsigned ROW     = 4,
  parameter int unsigned COL     = 4,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BIT-1:0]    data_in,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [BIT-1:0]    buf_wdata,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [BIT-1:0]    buf_rdata,
  output logic [BIT-1:0]    cmp_a,
  output logic [BIT-1:0]    cmp_b,
  input  logic [BIT-1:0]    cmp_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BIT-1:0]    data_out,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] WR_LAST = ADDR_W'(CHANNEL * ROW * COL - 1);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_cnt;
  logic [BIT-1:0]    max_reg;
  logic              a_lt_b;
  logic              win_step, win_clear, win_last;
  logic [ADDR_W-1:0] p0, p1, p2, p3;

  max_pool_addr_gen #(
    .CHANNEL (CHANNEL),
    .ROW     (ROW),
    .COL     (COL),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .clk   (clk),
    .rst_  (rst_),
    .clear (win_clear),
    .step  (win_step),
    .p0    (p0),
    .p1    (p1),
    .p2    (p2),
    .p3    (p3),
    .last  (win_last)
  );

  assign a_lt_b = is_neg(cmp_s);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_FILL;
      S_FILL: if (in_valid && (wr_cnt == WR_LAST)) state_nx = S_R0;
      S_R0:   state_nx = S_R1;
      S_R1:   state_nx = S_R2;
      S_R2:   state_nx = S_R3;
      S_R3:   state_nx = S_C3;
      S_C3:   state_nx = S_OUT;
      S_OUT:  if (out_ready) state_nx = win_last ? S_DONE : S_R0;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Read address leads the data by one cycle; outside R1..R3 it parks on p0.
  always_comb begin
    in_ready  = 1'b0;
    buf_we    = 1'b0;
    buf_raddr = p0;
    win_step  = 1'b0;
    win_clear = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: win_clear = start;
      S_FILL: begin
        in_ready = 1'b1;
        buf_we   = in_valid;
      end
      S_R1:   buf_raddr = p1;
      S_R2:   buf_raddr = p2;
      S_R3:   buf_raddr = p3;
      S_OUT:  win_step = out_ready;
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign buf_waddr = wr_cnt;
  assign buf_wdata = data_in;
  assign cmp_a     = max_reg;
  assign cmp_b     = buf_rdata;

  // Strict A<B replaces the running max, so ties keep the earlier element.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_cnt    <= '0;
      max_reg   <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (buf_we) wr_cnt <= (wr_cnt == WR_LAST) ? '0 : wr_cnt + ONE;
      case (state)
        S_R1: max_reg <= buf_rdata;
        S_R2, S_R3: if (a_lt_b) max_reg <= buf_rdata;
        S_C3: begin
          data_out  <= a_lt_b ? buf_rdata : max_reg;
          out_valid <= 1'b1;
        end
        S_OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
